// File: rtl/mini_mips_if.sv
// Byte-wide memory port between the mini_mips core (master) and memory (slave).
interface mini_mips_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic [DW-1:0] memdata;
  logic          memwrite;
  logic [AW-1:0] adr;
  logic [DW-1:0] writedata;

  modport master (input memdata, output memwrite, output adr, output writedata);
  modport slave  (output memdata, input memwrite, input adr, input writedata);
endinterface

// File: rtl/mini_mips.sv
// Multicycle 8-bit MIPS-subset core: 4-cycle byte fetch, then 2-4 execute cycles.
module mini_mips (
  input  logic        clk,
  input  logic        reset,
  mini_mips_if.master bus
);
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = 3;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4, S_DECODE, S_MEMADR,
    S_LBRD, S_LBWR, S_SBWR, S_RTEX, S_RTWR, S_ADDIWR, S_BEQEX, S_JEX
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic [DW-1:0] aluout_q, aluout_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] rf_q [NREG];

  logic          rf_we;
  logic [RW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] adr_c;
  logic          memwrite_c;

  // Instruction fields
  logic [5:0]    opcode, funct;
  logic [RW-1:0] rs, rt, rd;
  logic [DW-1:0] imm, imm_sh;
  logic          unused_ir;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[23:21];
  assign rt        = ir_q[18:16];
  assign rd        = ir_q[13:11];
  assign funct     = ir_q[5:0];
  assign imm       = ir_q[7:0];
  assign imm_sh    = {imm[5:0], 2'b00};
  assign unused_ir = ^{ir_q[25:24], ir_q[20:19], ir_q[15:14], ir_q[10:8]};

  // Register-file read ports; r0 is hardwired to zero
  logic [DW-1:0] rd_a, rd_b;
  assign rd_a = (rs == '0) ? '0 : rf_q[rs];
  assign rd_b = (rt == '0) ? '0 : rf_q[rt];

  // R-type ALU and funct legality
  logic [DW-1:0] alu_res;
  logic          funct_ok;
  always_comb begin
    alu_res  = '0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_res = a_q + b_q;
      FN_SUB:  alu_res = a_q - b_q;
      FN_AND:  alu_res = a_q & b_q;
      FN_OR:   alu_res = a_q | b_q;
      FN_SLT:  alu_res = DW'(a_q < b_q);
      default: funct_ok = 1'b0;
    endcase
  end

  // Next-state, datapath-next and memory-port decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    aluout_d   = aluout_q;
    a_d        = a_q;
    b_d        = b_q;
    rf_we      = 1'b0;
    rf_waddr   = rt;
    rf_wdata   = aluout_q;
    adr_c      = pc_q;
    memwrite_c = 1'b0;
    case (state_q)
      S_FETCH1: begin ir_d[7:0]   = bus.memdata; pc_d = pc_q + 8'd1; state_d = S_FETCH2; end
      S_FETCH2: begin ir_d[15:8]  = bus.memdata; pc_d = pc_q + 8'd1; state_d = S_FETCH3; end
      S_FETCH3: begin ir_d[23:16] = bus.memdata; pc_d = pc_q + 8'd1; state_d = S_FETCH4; end
      S_FETCH4: begin ir_d[31:24] = bus.memdata; pc_d = pc_q + 8'd1; state_d = S_DECODE; end
      S_DECODE: begin
        a_d      = rd_a;
        b_d      = rd_b;
        aluout_d = pc_q + imm_sh;
        case (opcode)
          OP_LB, OP_SB, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE:              state_d = funct_ok ? S_RTEX : S_FETCH1;
          OP_BEQ:                state_d = S_BEQEX;
          OP_J:                  state_d = S_JEX;
          default:               state_d = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        aluout_d = a_q + imm;
        case (opcode)
          OP_LB:   state_d = S_LBRD;
          OP_SB:   state_d = S_SBWR;
          OP_ADDI: state_d = S_ADDIWR;
          default: state_d = S_FETCH1;
        endcase
      end
      S_LBRD: begin
        adr_c   = aluout_q;
        mdr_d   = bus.memdata;
        state_d = S_LBWR;
      end
      S_LBWR: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        state_d  = S_FETCH1;
      end
      S_SBWR: begin
        adr_c      = aluout_q;
        memwrite_c = 1'b1;
        state_d    = S_FETCH1;
      end
      S_RTEX: begin
        aluout_d = alu_res;
        state_d  = S_RTWR;
      end
      S_RTWR: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        state_d  = S_FETCH1;
      end
      S_ADDIWR: begin
        rf_we   = 1'b1;
        state_d = S_FETCH1;
      end
      S_BEQEX: begin
        if (a_q == b_q) pc_d = aluout_q;
        state_d = S_FETCH1;
      end
      S_JEX: begin
        pc_d    = imm_sh;
        state_d = S_FETCH1;
      end
      default: state_d = S_FETCH1;
    endcase
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH1;
      pc_q     <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      aluout_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      aluout_q <= aluout_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end

  // Register file write port; writes to r0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign bus.adr       = adr_c;
  assign bus.memwrite  = memwrite_c;
  assign bus.writedata = b_q;
endmodule

// File: tb/tb_mini_mips.sv
// Directed program run for mini_mips against a byte-wide behavioural memory.
module tb_mini_mips;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  mini_mips_if bus ();
  mini_mips dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.memdata = mem[bus.adr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Advance one cycle; capture a store the way the memory would on the edge.
  task automatic tick();
    if (bus.memwrite === 1'b1) mem[bus.adr] = bus.writedata;
    @(posedge clk);
    #1;
  endtask

  task automatic put4(input logic [7:0] a, input logic [31:0] w);
    mem[a]          = w[7:0];
    mem[8'(a + 1)]  = w[15:8];
    mem[8'(a + 2)]  = w[23:16];
    mem[8'(a + 3)]  = w[31:24];
  endtask

  // Checks the four fetch addresses; returns in the DECODE cycle.
  task automatic expect_fetch(input logic [7:0] a);
    chk($sformatf("fetch_mw_%h", a), 8'(bus.memwrite), 8'h00);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fetch_adr_%h_%0d", a, k), bus.adr, 8'(a + k));
      tick();
    end
  endtask

  task automatic do_alu(input logic [7:0] a);
    expect_fetch(a);
    tick(); tick(); tick();
  endtask

  task automatic do_br(input logic [7:0] a);
    expect_fetch(a);
    tick(); tick();
  endtask

  task automatic do_sb(input logic [7:0] a, input logic [7:0] ea, input logic [7:0] ew);
    expect_fetch(a);
    tick(); tick();
    chk($sformatf("sb_adr_%h", a), bus.adr, ea);
    chk($sformatf("sb_wd_%h", a), bus.writedata, ew);
    chk($sformatf("sb_mw_%h", a), 8'(bus.memwrite), 8'h01);
    tick();
    chk($sformatf("sb_mw_after_%h", a), 8'(bus.memwrite), 8'h00);
  endtask

  task automatic do_lb(input logic [7:0] a, input logic [7:0] ea);
    expect_fetch(a);
    tick(); tick();
    chk($sformatf("lb_adr_%h", a), bus.adr, ea);
    chk($sformatf("lb_mw_%h", a), 8'(bus.memwrite), 8'h00);
    tick(); tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    put4(8'h04, 32'h20010005);  // ADDI r1,r0,5
    put4(8'h08, 32'hA0010080);  // SB   r1,0x80(r0)
    put4(8'h0C, 32'h80020090);  // LB   r2,0x90(r0)
    put4(8'h10, 32'hA0020081);  // SB   r2,0x81(r0)
    put4(8'h14, 32'h00221820);  // ADD  r3,r1,r2
    put4(8'h18, 32'hA0030082);  // SB   r3,0x82(r0)
    put4(8'h1C, 32'h00221822);  // SUB  r3,r1,r2
    put4(8'h20, 32'hA0030083);  // SB   r3,0x83(r0)
    put4(8'h24, 32'h0022182A);  // SLT  r3,r1,r2
    put4(8'h28, 32'hA0030084);  // SB   r3,0x84(r0)
    put4(8'h2C, 32'h10000002);  // BEQ  r0,r0,+2 -> 38
    put4(8'h38, 32'h10200002);  // BEQ  r1,r0,+2 (not taken)
    put4(8'h3C, 32'h08000050);  // J    0x50 -> 0x140 wraps to 40
    put4(8'h40, 32'h80040090);  // LB   r4,0x90(r0), aborted by reset
    mem[8'h90] = 8'h3C;
    mem[8'h85] = 8'hFF;

    // Reset state
    tick(); tick();
    chk("rst_adr", bus.adr, 8'h00);
    chk("rst_mw", 8'(bus.memwrite), 8'h00);
    chk("rst_wd", bus.writedata, 8'h00);
    reset = 1'b0;

    // All-zero word: illegal funct, refetch right after DECODE
    expect_fetch(8'h00);
    chk("illegal_dec_pc", bus.adr, 8'h04);
    tick();

    do_alu(8'h04);
    do_sb(8'h08, 8'h80, 8'h05);
    do_lb(8'h0C, 8'h90);
    do_sb(8'h10, 8'h81, 8'h3C);
    do_alu(8'h14);
    do_sb(8'h18, 8'h82, 8'h41);
    do_alu(8'h1C);
    do_sb(8'h20, 8'h83, 8'hC9);
    do_alu(8'h24);
    do_sb(8'h28, 8'h84, 8'h01);
    do_br(8'h2C);
    do_br(8'h38);
    do_br(8'h3C);

    // LB aborted by reset in its LBRD cycle
    expect_fetch(8'h40);
    tick(); tick();
    chk("abort_lbrd_adr", bus.adr, 8'h90);
    put4(8'h00, 32'hA0040085);  // SB r4,0x85(r0)
    #2 reset = 1'b1;
    #1;
    chk("abort_adr_now", bus.adr, 8'h00);
    chk("abort_mw_now", 8'(bus.memwrite), 8'h00);
    chk("abort_wd_now", bus.writedata, 8'h00);
    tick();
    chk("abort_mw_edge", 8'(bus.memwrite), 8'h00);
    chk("abort_adr_edge", bus.adr, 8'h00);
    reset = 1'b0;
    do_sb(8'h00, 8'h85, 8'h00);
    expect_fetch(8'h04);

    chk("mem_80", mem[8'h80], 8'h05);
    chk("mem_81", mem[8'h81], 8'h3C);
    chk("mem_82", mem[8'h82], 8'h41);
    chk("mem_83", mem[8'h83], 8'hC9);
    chk("mem_84", mem[8'h84], 8'h01);
    chk("mem_85", mem[8'h85], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mini_mips.md
# mini_mips

Multicycle 8-bit MIPS-subset processor core with a byte-wide memory port. It fetches a 32-bit instruction as four sequential bytes, then executes it over 2–4 further cycles. Eight 8-bit registers, an 8-bit PC and 8-bit addresses. Sits directly on a byte-wide, combinational-read memory model (`memdata` reflects `mem[adr]` in the same cycle).

## Interface
No parameters (data width 8, 8 registers, fixed).
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `memdata`  input  8  read data for the byte at `adr`; sampled on the rising edge.
- `memwrite`  output  1  write strobe; memory captures `writedata` at `adr` on the rising edge while high.
- `adr`  output  8  byte address: PC during fetch, ALU-out register during load/store.
- `writedata`  output  8  store data, equal to the register-B value (rt).

## Operation
- Instruction byte order: little-endian. The first fetched byte is `instr[7:0]`; the fourth is `instr[31:24]`.
- Fields:
  - opcode = `instr[31:26]`
  - rs = `instr[23:21]`
  - rt = `instr[18:16]`
  - rd = `instr[13:11]`
  - funct = `instr[5:0]`
  - imm = `instr[7:0]`
- Register file: 8×8. r0 always reads 0, and writes to it are ignored. Two read ports (A = rs, B = rt), one write port.
- Supported instructions:
  - LB 100000: rt ← mem[rs+imm]
  - SB 101000: mem[rs+imm] ← rt
  - R-type 000000, selected by funct:
    - ADD 100000
    - SUB 100010
    - AND 100100
    - OR 100101
    - SLT 101010: result is 1 if A<B unsigned, else 0
    - rd ← result
  - BEQ 000100: if rs==rt, PC ← PC+4+(imm<<2)
  - J 000010: PC ← imm<<2
  - ADDI 001000: rt ← rs+imm
- Arithmetic is modulo 256. Shifted immediates drop bits above 7.
- Unknown opcode or funct: return to FETCH1 with no architectural change.
- FSM states and transitions:
  - FETCH1–FETCH4: each asserts `adr`=PC, loads byte k of the IR, and sets PC ← PC+1.
  - DECODE: reads A and B; the ALU-out register ← PC+(imm<<2), the branch target. Next state by opcode:
    - LB, SB, ADDI → MEMADR
    - R-type → RTEX
    - BEQ → BEQEX
    - J → JEX
  - MEMADR: ALU-out ← A+imm. Next state:
    - LB → LBRD
    - SB → SBWR
    - ADDI → ADDIWR
  - LBRD: `adr`=ALU-out; MDR ← memdata → LBWR.
  - LBWR: rt ← MDR → FETCH1.
  - SBWR: `adr`=ALU-out, `memwrite`=1 → FETCH1.
  - RTEX: ALU-out ← A op B → RTWR.
  - RTWR: rd ← ALU-out → FETCH1.
  - ADDIWR: rt ← ALU-out → FETCH1.
  - BEQEX: if A==B, PC ← ALU-out → FETCH1.
  - JEX: PC ← imm<<2 → FETCH1.

## Timing
- Reset values, taking effect immediately on reset assertion:
  - state = FETCH1, PC = 00, IR = 0, MDR = 0, ALU-out = 0, A/B = 0, all registers = 0.
  - Outputs: `adr`=00, `memwrite`=0, `writedata`=00.
- Reset asserted mid-instruction aborts it. No partial write completes after the edge at which reset is seen.
- Cycles per instruction, including the 4 fetch cycles:
  - LB 8
  - SB, R-type, ADDI 7
  - BEQ, J 6
- `memwrite` is high for exactly one cycle (SBWR) per SB, and low in every other state.
- `adr` and `memwrite` are decoded from registered state/PC/ALU-out only. They have no combinational path from `memdata`.
- PC wraps FF→00. Branch and jump targets wrap modulo 256.

## Test plan
1. Reset, then release with memdata=00:
   - While reset is high: `adr`=00, `memwrite`=0, `writedata`=00.
   - After release, `adr` steps 00,01,02,03 on successive cycles.
   - Instruction 00000000 (all-zero R-type, funct 0) is illegal: the core refetches at `adr`=04 after DECODE.
2. ADDI r1,r0,5 (bytes 05 00 01 20), then SB r1,0x10(r0) (bytes 10 00 01 A0):
   - In the SBWR cycle, `adr`=10, `writedata`=05, `memwrite`=1 for exactly one cycle.
   - The next fetch starts at `adr`=08.
3. LB r2,0x10(r0) (bytes 10 00 02 80), with memdata=3C in the LBRD cycle:
   - r2=3C.
   - A following SB r2 shows `writedata`=3C.
   - LB takes 8 cycles.
4. ADD r3,r1,r2 (bytes 20 18 22 00), with r1=05 and r2=3C:
   - r3=41.
   - SUB gives C9.
   - SLT r3,r1,r2 gives 01.
   - A store of r3 confirms each result.
5. Branches and jumps:
   - BEQ r0,r0,+2 at PC 00 (bytes 02 00 00 10): next fetch `adr`=0C.
   - BEQ r1,r0 with r1≠0: next fetch `adr`=04.
   - J 5 (bytes 05 00 00 08): next fetch `adr`=14.
6. Reset asserted during the LBRD cycle of an LB:
   - `adr`=00 immediately.
   - The target register is unchanged (0).
   - No `memwrite` pulse occurs.
